// File: rtl/stb_ptr_pkg.sv
// Store-buffer pointer controller shared definitions.
// Holds the thread/entry geometry, pointer types and the helper that turns
// a [hptr, wptr) pointer pair into a per-entry valid mask.
package stb_ptr_pkg;

  localparam int unsigned NTHR = 8;
  localparam int unsigned NENT = 8;
  localparam int unsigned PTRW = 3;

  typedef logic [2:0]      tid_t;
  typedef logic [PTRW:0]   ptr_t;   // index plus wrap bit
  typedef logic [PTRW-1:0] idx_t;

  // Entry i is valid when its distance from hptr (mod NENT) is below the
  // occupancy wptr-hptr. Works across the wrap because the occupancy is taken
  // on the full PTRW+1 bit pointers.
  function automatic logic [NENT-1:0] ptr_range_mask(ptr_t hptr, ptr_t wptr);
    logic [NENT-1:0] mask;
    ptr_t            cnt;
    idx_t            off;
    cnt  = wptr - hptr;
    mask = '0;
    for (int unsigned i = 0; i < NENT; i++) begin
      off     = idx_t'(i) - hptr[PTRW-1:0];
      mask[i] = ({1'b0, off} < cnt);
    end
    return mask;
  endfunction

endpackage

// File: rtl/stb_ptr_thr.sv
// One thread's store-buffer pointers.
// Keeps wptr (next alloc), rptr (next drain read) and hptr (oldest unretired),
// derives full/empty, decides whether alloc/retire are legal and produces the
// compare valid mask (after a same-cycle retire, before a same-cycle alloc).
// Optional STB_PTR_ERR_EN adds a sticky illegal-event flag.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   alloc_i            alloc request for this thread
//   drain_i            granted drain read for this thread (only when can_drain_o)
//   retire_i           retire request for this thread
//   wptr_idx_o         entry index of next alloc
//   rptr_idx_o         entry index of next drain read
//   full_o, empty_o    occupancy status
//   can_drain_o        an allocated entry has not yet been read
//   alloc_ok_o         alloc request accepted this cycle
//   mask_o             valid-entry mask for CAM compare
//   err_o              sticky illegal-event flag (STB_PTR_ERR_EN only)
module stb_ptr_thr
  import stb_ptr_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alloc_i,
  input  logic            drain_i,
  input  logic            retire_i,
  output idx_t            wptr_idx_o,
  output idx_t            rptr_idx_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            can_drain_o,
  output logic            alloc_ok_o,
  output logic [NENT-1:0] mask_o
`ifdef STB_PTR_ERR_EN
  ,
  output logic            err_o
`endif
);

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t hptr_q, hptr_d;

  logic full;
  logic retire_ok;
  logic alloc_ok;

  assign full      = (wptr_q[PTRW] != hptr_q[PTRW]) &&
                     (wptr_q[PTRW-1:0] == hptr_q[PTRW-1:0]);
  assign retire_ok = retire_i && (hptr_q != rptr_q);
  // A retire in the same cycle frees a slot, so a full thread can still accept.
  assign alloc_ok  = alloc_i && (!full || retire_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    hptr_d = hptr_q;
    if (alloc_ok)  wptr_d = wptr_q + ptr_t'(1);
    if (drain_i)   rptr_d = rptr_q + ptr_t'(1);
    if (retire_ok) hptr_d = hptr_q + ptr_t'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      hptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      hptr_q <= hptr_d;
    end
  end

  assign wptr_idx_o  = wptr_q[PTRW-1:0];
  assign rptr_idx_o  = rptr_q[PTRW-1:0];
  assign full_o      = full;
  assign empty_o     = (wptr_q == hptr_q);
  assign can_drain_o = (rptr_q != wptr_q);
  assign alloc_ok_o  = alloc_ok;
  // Uses the post-retire hptr but the pre-alloc wptr.
  assign mask_o      = ptr_range_mask(hptr_d, wptr_q);

`ifdef STB_PTR_ERR_EN
  logic err_q, err_d;
  assign err_d = err_q || (alloc_i && !alloc_ok) || (retire_i && !retire_ok);
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign err_o = err_q;
`endif

endmodule

// File: rtl/stb_ptr_ctl.sv
// Store-buffer pointer/occupancy controller in front of the 64-entry STB CAM.
// Decodes per-thread alloc/drain/retire/load-compare requests, arbitrates the
// single CAM rw port (alloc beats drain) and registers all CAM-facing strobes
// so they appear one cycle after the request as single-cycle pulses.
// Optional feature macro: STB_PTR_ERR_EN adds stb_ptr_err (sticky per thread).
// Ports:
//   l2clk, rst                         clock, synchronous active-high reset
//   st_alloc_vld/tid                   store allocate
//   st_drain_req/tid, st_drain_gnt     drain read request and comb. grant
//   st_retire_vld/tid                  retire (frees oldest entry)
//   ld_cam_req/tid                     load RAW compare request
//   stb_cam_rw_ptr/rw_tid              registered rw port address
//   stb_cam_wptr_vld/rptr_vld          registered write/read strobes
//   stb_cam_vld/cm_tid/line_en         registered compare strobe, thread, mask
//   stb_full/stb_empty                 per-thread occupancy status
//   stb_ptr_err                        sticky illegal-event flags (STB_PTR_ERR_EN)
module stb_ptr_ctl
  import stb_ptr_pkg::*;
(
  input  logic            l2clk,
  input  logic            rst,
  input  logic            st_alloc_vld,
  input  logic [2:0]      st_alloc_tid,
  input  logic            st_drain_req,
  input  logic [2:0]      st_drain_tid,
  output logic            st_drain_gnt,
  input  logic            st_retire_vld,
  input  logic [2:0]      st_retire_tid,
  input  logic            ld_cam_req,
  input  logic [2:0]      ld_cam_tid,
  output logic [2:0]      stb_cam_rw_ptr,
  output logic [2:0]      stb_cam_rw_tid,
  output logic            stb_cam_wptr_vld,
  output logic            stb_cam_rptr_vld,
  output logic            stb_cam_vld,
  output logic [2:0]      stb_cam_cm_tid,
  output logic [NENT-1:0] stb_cam_line_en,
  output logic [NTHR-1:0] stb_full,
  output logic [NTHR-1:0] stb_empty
`ifdef STB_PTR_ERR_EN
  ,
  output logic [NTHR-1:0] stb_ptr_err
`endif
);

  logic [NTHR-1:0] alloc_t, drain_t, retire_t;
  logic [NTHR-1:0] alloc_ok, can_drain, full, empty;
  idx_t            wptr_idx [NTHR];
  idx_t            rptr_idx [NTHR];
  logic [NENT-1:0] mask     [NTHR];

  logic any_alloc;
  logic drain_gnt;

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    assign alloc_t[t]  = st_alloc_vld  && (st_alloc_tid  == tid_t'(t));
    assign retire_t[t] = st_retire_vld && (st_retire_tid == tid_t'(t));
    assign drain_t[t]  = drain_gnt     && (st_drain_tid  == tid_t'(t));

    stb_ptr_thr u_thr (
      .clk_i       (l2clk),
      .rst_i       (rst),
      .alloc_i     (alloc_t[t]),
      .drain_i     (drain_t[t]),
      .retire_i    (retire_t[t]),
      .wptr_idx_o  (wptr_idx[t]),
      .rptr_idx_o  (rptr_idx[t]),
      .full_o      (full[t]),
      .empty_o     (empty[t]),
      .can_drain_o (can_drain[t]),
      .alloc_ok_o  (alloc_ok[t]),
      .mask_o      (mask[t])
`ifdef STB_PTR_ERR_EN
      ,
      .err_o       (stb_ptr_err[t])
`endif
    );
  end

  // Only an accepted alloc occupies the rw port; an ignored one leaves it free.
  assign any_alloc    = |alloc_ok;
  assign drain_gnt    = !rst && st_drain_req && !any_alloc && can_drain[st_drain_tid];
  assign st_drain_gnt = drain_gnt;

  logic            wptr_vld_q, wptr_vld_d;
  logic            rptr_vld_q, rptr_vld_d;
  logic [2:0]      rw_ptr_q,   rw_ptr_d;
  logic [2:0]      rw_tid_q,   rw_tid_d;
  logic            cam_vld_q,  cam_vld_d;
  logic [2:0]      cm_tid_q,   cm_tid_d;
  logic [NENT-1:0] line_en_q,  line_en_d;

  always_comb begin
    wptr_vld_d = any_alloc;
    rptr_vld_d = drain_gnt;
    rw_ptr_d   = '0;
    rw_tid_d   = '0;
    if (any_alloc) begin
      rw_ptr_d = wptr_idx[st_alloc_tid];
      rw_tid_d = st_alloc_tid;
    end else if (drain_gnt) begin
      rw_ptr_d = rptr_idx[st_drain_tid];
      rw_tid_d = st_drain_tid;
    end
    cam_vld_d = ld_cam_req;
    cm_tid_d  = ld_cam_req ? ld_cam_tid : 3'd0;
    line_en_d = ld_cam_req ? mask[ld_cam_tid] : '0;
  end

  always_ff @(posedge l2clk) begin
    if (rst) begin
      wptr_vld_q <= 1'b0;
      rptr_vld_q <= 1'b0;
      rw_ptr_q   <= '0;
      rw_tid_q   <= '0;
      cam_vld_q  <= 1'b0;
      cm_tid_q   <= '0;
      line_en_q  <= '0;
    end else begin
      wptr_vld_q <= wptr_vld_d;
      rptr_vld_q <= rptr_vld_d;
      rw_ptr_q   <= rw_ptr_d;
      rw_tid_q   <= rw_tid_d;
      cam_vld_q  <= cam_vld_d;
      cm_tid_q   <= cm_tid_d;
      line_en_q  <= line_en_d;
    end
  end

  assign stb_cam_wptr_vld = wptr_vld_q;
  assign stb_cam_rptr_vld = rptr_vld_q;
  assign stb_cam_rw_ptr   = rw_ptr_q;
  assign stb_cam_rw_tid   = rw_tid_q;
  assign stb_cam_vld      = cam_vld_q;
  assign stb_cam_cm_tid   = cm_tid_q;
  assign stb_cam_line_en  = line_en_q;
  assign stb_full         = full;
  assign stb_empty        = empty;

endmodule

// File: tb/tb_stb_ptr_ctl.sv
// Directed bench for stb_ptr_ctl: linear sequence of steps, immediate assertions.
module tb_stb_ptr_ctl;

  logic       l2clk = 1'b0;
  logic       rst;
  logic       st_alloc_vld;
  logic [2:0] st_alloc_tid;
  logic       st_drain_req;
  logic [2:0] st_drain_tid;
  logic       st_drain_gnt;
  logic       st_retire_vld;
  logic [2:0] st_retire_tid;
  logic       ld_cam_req;
  logic [2:0] ld_cam_tid;
  logic [2:0] stb_cam_rw_ptr;
  logic [2:0] stb_cam_rw_tid;
  logic       stb_cam_wptr_vld;
  logic       stb_cam_rptr_vld;
  logic       stb_cam_vld;
  logic [2:0] stb_cam_cm_tid;
  logic [7:0] stb_cam_line_en;
  logic [7:0] stb_full;
  logic [7:0] stb_empty;
`ifdef STB_PTR_ERR_EN
  logic [7:0] stb_ptr_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 l2clk = ~l2clk;

  stb_ptr_ctl dut (
    .l2clk            (l2clk),
    .rst              (rst),
    .st_alloc_vld     (st_alloc_vld),
    .st_alloc_tid     (st_alloc_tid),
    .st_drain_req     (st_drain_req),
    .st_drain_tid     (st_drain_tid),
    .st_drain_gnt     (st_drain_gnt),
    .st_retire_vld    (st_retire_vld),
    .st_retire_tid    (st_retire_tid),
    .ld_cam_req       (ld_cam_req),
    .ld_cam_tid       (ld_cam_tid),
    .stb_cam_rw_ptr   (stb_cam_rw_ptr),
    .stb_cam_rw_tid   (stb_cam_rw_tid),
    .stb_cam_wptr_vld (stb_cam_wptr_vld),
    .stb_cam_rptr_vld (stb_cam_rptr_vld),
    .stb_cam_vld      (stb_cam_vld),
    .stb_cam_cm_tid   (stb_cam_cm_tid),
    .stb_cam_line_en  (stb_cam_line_en),
    .stb_full         (stb_full),
    .stb_empty        (stb_empty)
`ifdef STB_PTR_ERR_EN
    ,
    .stb_ptr_err      (stb_ptr_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge l2clk);
    #1;
  endtask

  task automatic clr();
    st_alloc_vld  = 1'b0;
    st_alloc_tid  = 3'd0;
    st_drain_req  = 1'b0;
    st_drain_tid  = 3'd0;
    st_retire_vld = 1'b0;
    st_retire_tid = 3'd0;
    ld_cam_req    = 1'b0;
    ld_cam_tid    = 3'd0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_wvld",  stb_cam_wptr_vld, 0);
    chk("rst_rvld",  stb_cam_rptr_vld, 0);
    chk("rst_cvld",  stb_cam_vld, 0);
    chk("rst_rwptr", stb_cam_rw_ptr, 0);
    chk("rst_rwtid", stb_cam_rw_tid, 0);
    chk("rst_cmtid", stb_cam_cm_tid, 0);
    chk("rst_lnen",  stb_cam_line_en, 0);
    chk("rst_empty", stb_empty, 8'hFF);
    chk("rst_full",  stb_full, 8'h00);
    chk("rst_gnt",   st_drain_gnt, 0);
`ifdef STB_PTR_ERR_EN
    chk("rst_err",   stb_ptr_err, 8'h00);
`endif

    // 1: three allocs on tid2, then compare
    for (int i = 0; i < 3; i++) begin
      st_alloc_vld = 1'b1; st_alloc_tid = 3'd2;
      step();
      chk("t1_wvld", stb_cam_wptr_vld, 1);
      chk("t1_rwptr", stb_cam_rw_ptr, i);
      chk("t1_rwtid", stb_cam_rw_tid, 2);
    end
    clr();
    chk("t1_empty", stb_empty, 8'hFB);
    ld_cam_req = 1'b1; ld_cam_tid = 3'd2;
    step();
    clr();
    chk("t1_wvld_off", stb_cam_wptr_vld, 0);
    chk("t1_cvld", stb_cam_vld, 1);
    chk("t1_cmtid", stb_cam_cm_tid, 2);
    chk("t1_lnen", stb_cam_line_en, 8'h07);
    step();
    chk("t1_cvld_off", stb_cam_vld, 0);

    // 2: fill tid5, ninth alloc ignored
    for (int i = 0; i < 8; i++) begin
      st_alloc_vld = 1'b1; st_alloc_tid = 3'd5;
      step();
    end
    chk("t2_full", stb_full, 8'h20);
    chk("t2_rwptr7", stb_cam_rw_ptr, 7);
    step();
    clr();
    chk("t2_wvld_ovf", stb_cam_wptr_vld, 0);
    chk("t2_full_hold", stb_full, 8'h20);
`ifdef STB_PTR_ERR_EN
    chk("t2_err", stb_ptr_err, 8'h20);
`endif

    // 3: alloc beats drain on tid0
    st_alloc_vld = 1'b1; st_alloc_tid = 3'd0;
    st_drain_req = 1'b1; st_drain_tid = 3'd0;
    #1;
    chk("t3_gnt0", st_drain_gnt, 0);
    step();
    st_alloc_vld = 1'b0;
    chk("t3_wvld", stb_cam_wptr_vld, 1);
    chk("t3_rvld0", stb_cam_rptr_vld, 0);
    chk("t3_rwtid", stb_cam_rw_tid, 0);
    #1;
    chk("t3_gnt1", st_drain_gnt, 1);
    step();
    clr();
    chk("t3_rvld", stb_cam_rptr_vld, 1);
    chk("t3_wvld_off", stb_cam_wptr_vld, 0);
    chk("t3_rwptr", stb_cam_rw_ptr, 0);

    // Drain of an empty thread is never granted
    st_drain_req = 1'b1; st_drain_tid = 3'd3;
    #1;
    chk("empty_gnt", st_drain_gnt, 0);
    step();
    clr();
    chk("empty_rvld", stb_cam_rptr_vld, 0);

    // 4: wrap on tid7
    for (int i = 0; i < 8; i++) begin
      st_alloc_vld = 1'b1; st_alloc_tid = 3'd7;
      step();
    end
    clr();
    chk("t4_full", stb_full, 8'hA0);
    for (int i = 0; i < 8; i++) begin
      st_drain_req = 1'b1; st_drain_tid = 3'd7;
      #1;
      chk("t4_gnt", st_drain_gnt, 1);
      step();
      chk("t4_rvld", stb_cam_rptr_vld, 1);
      chk("t4_rdptr", stb_cam_rw_ptr, i);
    end
    clr();
    for (int i = 0; i < 8; i++) begin
      st_retire_vld = 1'b1; st_retire_tid = 3'd7;
      step();
    end
    clr();
    chk("t4_empty", stb_empty, 8'hDA);
    chk("t4_full2", stb_full, 8'h20);
    for (int i = 0; i < 3; i++) begin
      st_alloc_vld = 1'b1; st_alloc_tid = 3'd7;
      step();
      chk("t4_wvld", stb_cam_wptr_vld, 1);
      chk("t4_wrptr", stb_cam_rw_ptr, i);
    end
    clr();
    ld_cam_req = 1'b1; ld_cam_tid = 3'd7;
    step();
    clr();
    chk("t4_lnen", stb_cam_line_en, 8'h07);
    chk("t4_cmtid", stb_cam_cm_tid, 7);

    // 5: full tid1, same-cycle retire + alloc + compare
    for (int i = 0; i < 8; i++) begin
      st_alloc_vld = 1'b1; st_alloc_tid = 3'd1;
      step();
    end
    clr();
    chk("t5_full", stb_full, 8'h22);
    st_drain_req = 1'b1; st_drain_tid = 3'd1;
    step();
    clr();
    chk("t5_rvld", stb_cam_rptr_vld, 1);
    chk("t5_rdptr", stb_cam_rw_ptr, 0);
    st_retire_vld = 1'b1; st_retire_tid = 3'd1;
    st_alloc_vld  = 1'b1; st_alloc_tid  = 3'd1;
    ld_cam_req    = 1'b1; ld_cam_tid    = 3'd1;
    step();
    clr();
    chk("t5_wvld", stb_cam_wptr_vld, 1);
    chk("t5_wrptr", stb_cam_rw_ptr, 0);
    chk("t5_rwtid", stb_cam_rw_tid, 1);
    chk("t5_lnen", stb_cam_line_en, 8'hFE);
    chk("t5_full_hold", stb_full, 8'h22);
    // Retire with nothing issued is ignored
    st_retire_vld = 1'b1; st_retire_tid = 3'd1;
    step();
    clr();
    chk("t5_ret_ign", stb_full, 8'h22);
`ifdef STB_PTR_ERR_EN
    chk("t5_err", stb_ptr_err, 8'h22);
`endif

    // 6: reset mid-stream with requests pending
    st_drain_req = 1'b1; st_drain_tid = 3'd1;
    st_alloc_vld = 1'b1; st_alloc_tid = 3'd2;
    ld_cam_req   = 1'b1; ld_cam_tid   = 3'd7;
    rst = 1'b1;
    #1;
    chk("t6_gnt_rst", st_drain_gnt, 0);
    step();
    chk("t6_wvld", stb_cam_wptr_vld, 0);
    chk("t6_rvld", stb_cam_rptr_vld, 0);
    chk("t6_cvld", stb_cam_vld, 0);
    chk("t6_lnen", stb_cam_line_en, 0);
    chk("t6_rwptr", stb_cam_rw_ptr, 0);
    chk("t6_empty", stb_empty, 8'hFF);
    chk("t6_full", stb_full, 8'h00);
`ifdef STB_PTR_ERR_EN
    chk("t6_err", stb_ptr_err, 8'h00);
`endif
    rst = 1'b0;
    clr();
    st_drain_req = 1'b1; st_drain_tid = 3'd1;
    #1;
    chk("t6_gnt_post", st_drain_gnt, 0);
    step();
    clr();
    chk("t6_rvld_post", stb_cam_rptr_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
